serial_link_phy_ctrl: RTL and testbench



---
 rtl/serial_link_phy_ctrl.sv | 166 ++++++++++++++++
 tb/tb_serial_link_phy_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_link_phy_ctrl.sv
// serial_link_phy_ctrl: PHY TX bring-up sequencer and round-robin beat arbiter; training stage built only with SERIAL_LINK_PHY_CTRL_TRAIN_EN
module serial_link_phy_ctrl #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned MaxClkDiv = 32,
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned TrainBeats = 8,
    parameter logic [DataWidth-1:0] TrainPattern = 16'hA5A5,
    localparam int unsigned CW = $clog2(MaxClkDiv) + 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cfg_en_i,
    input  logic [CW-1:0]                      cfg_clk_div_i,
    input  logic                               cfg_apply_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    output logic [CW-1:0]                      phy_clk_div_o,
    output logic [CW-1:0]                      phy_clk_shift_start_o,
    output logic [CW-1:0]                      phy_clk_shift_end_o,
    output logic [DataWidth-1:0]               phy_data_out_o,
    output logic                               phy_data_out_valid_o,
    input  logic                               phy_data_out_ready_i,
    output logic [1:0]                         state_o,
    output logic                               link_up_o
);
    typedef enum logic [1:0] {S_OFF, S_SETTLE, S_TRAIN, S_ACTIVE} state_e;
    localparam int unsigned CntMax = SettleCycles > TrainBeats ? SettleCycles : TrainBeats;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam int unsigned IdxW = NumReq > 1 ? $clog2(NumReq) : 1;

    function automatic logic [3*CW-1:0] clk_cfg(input logic [CW-1:0] raw);
        logic [CW-1:0] c, d, s;
        c = raw < CW'(2) ? CW'(2) : raw > CW'(MaxClkDiv) ? CW'(MaxClkDiv) : raw;
        d = {c[CW-1:1], 1'b0};
        s = d >> 2;
        return {d, s, s + (d >> 1)};
    endfunction

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic valid_q, valid_d, pend_q, pend_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [IdxW-1:0] rr_q, rr_d, gnt_idx, scan;
    logic [CW-1:0] pend_div_q, eff_div;
    logic [3*CW-1:0] cfg_q;
    logic eff_pend, drain, latch, gnt_found, gnt;

    assign eff_pend = pend_q | cfg_apply_i;
    assign eff_div = cfg_apply_i ? cfg_clk_div_i : pend_div_q;
    // a pending reconfiguration waits until the output register is free
    assign drain = eff_pend && (!valid_q || phy_data_out_ready_i);
    assign gnt = state_q == S_ACTIVE && cfg_en_i && !eff_pend && gnt_found
                 && (!valid_q || phy_data_out_ready_i);
    assign req_ready_o = gnt ? NumReq'(1) << gnt_idx : '0;
    assign {phy_clk_div_o, phy_clk_shift_start_o, phy_clk_shift_end_o} = cfg_q;
    assign phy_data_out_o = data_q;
    assign phy_data_out_valid_o = valid_q;
    assign state_o = state_q;
    assign link_up_o = state_q == S_ACTIVE;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx = rr_q;
        scan = rr_q;
        for (int i = 0; i < NumReq; i++) begin
            scan = scan == IdxW'(NumReq - 1) ? '0 : scan + 1'b1;
            if (!gnt_found && req_valid_i[scan]) begin
                gnt_found = 1'b1;
                gnt_idx = scan;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        valid_d = valid_q;
        data_d = data_q;
        rr_d = rr_q;
        pend_d = 1'b0;
        latch = 1'b0;
        if (!cfg_en_i) begin
            state_d = S_OFF;
            valid_d = 1'b0;
            latch = eff_pend;
        end else if ((state_q == S_TRAIN || state_q == S_ACTIVE) && drain) begin
            state_d = S_SETTLE;
            cnt_d = '0;
            valid_d = 1'b0;
            latch = 1'b1;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d = S_SETTLE;
                    cnt_d = '0;
                    latch = cfg_apply_i;
                end
                S_SETTLE: begin
                    if (cfg_apply_i) begin
                        cnt_d = '0;
                        latch = 1'b1;
                    end else if (cnt_q == CntW'(SettleCycles - 1)) begin
`ifdef SERIAL_LINK_PHY_CTRL_TRAIN_EN
                        state_d = S_TRAIN;
                        cnt_d = '0;
                        valid_d = 1'b1;
                        data_d = TrainPattern;
`else
                        state_d = S_ACTIVE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef SERIAL_LINK_PHY_CTRL_TRAIN_EN
                S_TRAIN: begin
                    pend_d = eff_pend;
                    if (phy_data_out_ready_i) begin
                        cnt_d = cnt_q + 1'b1;
                        data_d = ~data_q;
                        if (cnt_q == CntW'(TrainBeats - 1)) begin
                            state_d = S_ACTIVE;
                            valid_d = 1'b0;
                        end
                    end
                end
`endif
                S_ACTIVE: begin
                    pend_d = eff_pend;
                    if (gnt) begin
                        valid_d = 1'b1;
                        data_d = req_data_i[gnt_idx];
                        rr_d = gnt_idx;
                    end else if (phy_data_out_ready_i) begin
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_OFF;
            cnt_q <= '0;
            valid_q <= 1'b0;
            data_q <= '0;
            rr_q <= IdxW'(NumReq - 1);
            pend_q <= 1'b0;
            pend_div_q <= '0;
            cfg_q <= clk_cfg(CW'(MaxClkDiv));
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            data_q <= data_d;
            rr_q <= rr_d;
            pend_q <= pend_d;
            pend_div_q <= eff_div;
            if (latch) cfg_q <= clk_cfg(eff_div);
        end
    end
endmodule

// File: tb/tb_serial_link_phy_ctrl.sv
// tb_serial_link_phy_ctrl: directed bring-up, arbitration, backpressure and reconfiguration vectors
module tb_serial_link_phy_ctrl;
    logic clk = 1'b0;
    logic rst, en, apply, pr, valid, link_up;
    logic [5:0] div_in, div, s_start, s_end;
    logic [1:0][15:0] rd;
    logic [1:0] rv, ready, state;
    logic [15:0] data;
    int checks = 0;
    int errors = 0;

    serial_link_phy_ctrl dut (
        .clk_i(clk),
        .rst_i(rst),
        .cfg_en_i(en),
        .cfg_clk_div_i(div_in),
        .cfg_apply_i(apply),
        .req_data_i(rd),
        .req_valid_i(rv),
        .req_ready_o(ready),
        .phy_clk_div_o(div),
        .phy_clk_shift_start_o(s_start),
        .phy_clk_shift_end_o(s_end),
        .phy_data_out_o(data),
        .phy_data_out_valid_o(valid),
        .phy_data_out_ready_i(pr),
        .state_o(state),
        .link_up_o(link_up)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic pc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cfg(input logic [5:0] d, input logic [5:0] s, input logic [5:0] e);
        check("cfg_div", div, d);
        check("cfg_start", s_start, s);
        check("cfg_end", s_end, e);
    endtask

    task automatic settle_seq();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("settle_state", state, 1);
            check("settle_valid", valid, 0);
            check("settle_ready", ready, 0);
            pc();
        end
    endtask

    initial begin
        int g;
        rst = 1'b1; en = 1'b1; apply = 1'b0; div_in = '0; pr = 1'b0; rv = '0;
        rd[0] = 16'h1111; rd[1] = 16'h2222;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_valid", valid, 0);
        check("rst_ready", ready, 0);
        check("rst_data", data, 0);
        check("rst_link", link_up, 0);
        check_cfg(32, 8, 24);
        pc();
        rst = 1'b0; apply = 1'b1; div_in = 13;
        pc();
        apply = 1'b0;
        settle_seq();
        check_cfg(12, 3, 9);
`ifdef SERIAL_LINK_PHY_CTRL_TRAIN_EN
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("train_state", state, 2);
                check("train_hold", data, b % 2 ? 16'h5A5A : 16'hA5A5);
                check("train_valid", valid, 1);
                pc();
            end
            pr = 1'b1;
            @(negedge clk);
            check("train_beat", data, b % 2 ? 16'h5A5A : 16'hA5A5);
            check("train_noready", ready, 0);
            pc();
            pr = 1'b0;
        end
`endif
        @(negedge clk);
        check("up_state", state, 3);
        check("up_link", link_up, 1);
        check("up_valid", valid, 0);
        pc();
        rv = 2'b11; pr = 1'b1;
        g = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_ready", ready, 2'b01 << g);
            if (i > 0) begin
                check("rr_valid", valid, 1);
                check("rr_data", data, g ? 16'h1111 : 16'h2222);
            end
            pc();
            g ^= 1;
        end
        pr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data", data, 16'h2222);
            check("bp_valid", valid, 1);
            check("bp_ready", ready, 0);
            pc();
        end
        apply = 1'b1; div_in = 8;
        @(negedge clk);
        check("pend_ready", ready, 0);
        pc();
        apply = 1'b0;
        @(negedge clk);
        check("pend_div_hold", div, 12);
        check("pend_state", state, 3);
        check("pend_data", data, 16'h2222);
        pc();
        pr = 1'b1;
        @(negedge clk);
        check("pend_nogrant", ready, 0);
        pc();
        pr = 1'b0;
        settle_seq();
        check_cfg(8, 2, 6);
`ifdef SERIAL_LINK_PHY_CTRL_TRAIN_EN
        @(negedge clk);
        check("retrain_state", state, 2);
        check("retrain_data", data, 16'hA5A5);
        pc();
        en = 1'b0;
        @(negedge clk);
        check("dis_noready", ready, 0);
        pc();
`else
        @(negedge clk);
        check("regrant_ready", ready, 2'b01);
        pc();
        en = 1'b0;
        @(negedge clk);
        check("held_data", data, 16'h1111);
        check("dis_noready", ready, 0);
        pc();
`endif
        @(negedge clk);
        check("off_state", state, 0);
        check("off_valid", valid, 0);
        check("off_ready", ready, 0);
        pc();
        apply = 1'b1; div_in = 1;
        pc();
        apply = 1'b0;
        @(negedge clk);
        check_cfg(2, 0, 1);
        pc();
        apply = 1'b1; div_in = 63;
        pc();
        apply = 1'b0;
        @(negedge clk);
        check_cfg(32, 8, 24);
        check("off_still", state, 0);
        pc();
        en = 1'b1;
        pc();
        settle_seq();
`ifdef SERIAL_LINK_PHY_CTRL_TRAIN_EN
        pr = 1'b1;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check("train2_data", data, b % 2 ? 16'h5A5A : 16'hA5A5);
            check("train2_state", state, 2);
            pc();
        end
        pr = 1'b0;
`endif
        @(negedge clk);
        check("reup_state", state, 3);
        check("reup_link", link_up, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
